// File: rtl/stream_loader.sv
// rtl/stream_loader.sv - Avalon-ST packet loader filling the qsys_player sample buffer
module stream_loader #(
    parameter int timeBits    = 10,
    parameter int words_log_2 = 0,
    parameter int AUTO_START  = 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             arm,
    input  logic                             abort,
    input  logic                             sink_valid,
    output logic                             sink_ready,
    input  logic [31:0]                      sink_data,
    input  logic                             sink_startofpacket,
    input  logic                             sink_endofpacket,
    output logic                             buffer_write,
    output logic [timeBits+words_log_2-1:0]  buffer_address,
    output logic [31:0]                      buffer_writedata,
    output logic                             loaded,
    output logic                             overflow,
    output logic                             pkt_error,
    output logic [timeBits+words_log_2:0]    word_count,
    output logic                             start_req
);

    localparam int AW    = timeBits + words_log_2;
    localparam int DEPTH = 1 << AW;

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_W   = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SOP = 2'd1,
        LOAD     = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW:0]     word_count_q, word_count_d;
    logic            buffer_write_q, buffer_write_d;
    logic [AW-1:0]   buffer_address_q, buffer_address_d;
    logic [31:0]     buffer_writedata_q, buffer_writedata_d;
    logic            loaded_q, loaded_d;
    logic            overflow_q, overflow_d;
    logic            pkt_error_q, pkt_error_d;
    logic            start_req_q, start_req_d;

    logic            beat;
    logic            do_write;
    logic            restart;
    logic [AW:0]     count_next;

    // Ready comes only from the state register so upstream sees no combinational loop.
    assign sink_ready = (state_q == WAIT_SOP) || (state_q == LOAD);
    assign beat       = sink_valid && sink_ready;

    // Next-state and next-output decode; abort beats arm beats a data beat.
    always_comb begin
        state_d            = state_q;
        word_count_d       = word_count_q;
        buffer_write_d     = 1'b0;
        buffer_address_d   = buffer_address_q;
        buffer_writedata_d = buffer_writedata_q;
        loaded_d           = loaded_q;
        overflow_d         = overflow_q;
        pkt_error_d        = pkt_error_q;
        start_req_d        = 1'b0;
        do_write           = 1'b0;
        restart            = 1'b0;
        count_next         = word_count_q;

        if (abort) begin
            state_d = IDLE;
        end else if (arm) begin
            state_d      = WAIT_SOP;
            word_count_d = '0;
            loaded_d     = 1'b0;
            overflow_d   = 1'b0;
            pkt_error_d  = 1'b0;
        end else if (beat) begin
            case (state_q)
                WAIT_SOP: begin
                    // Beats ahead of the first SOP are swallowed.
                    if (sink_startofpacket) begin
                        do_write = 1'b1;
                        restart  = 1'b1;
                    end
                end
                LOAD: begin
                    do_write = 1'b1;
                    // A fresh SOP mid-packet restarts the load from address 0.
                    if (sink_startofpacket) begin
                        restart     = 1'b1;
                        pkt_error_d = 1'b1;
                    end
                end
                default: begin
                    do_write = 1'b0;
                end
            endcase

            if (do_write) begin
                count_next         = restart ? ONE_W : (word_count_q + ONE_W);
                buffer_write_d     = 1'b1;
                buffer_address_d   = restart ? '0 : word_count_q[AW-1:0];
                buffer_writedata_d = sink_data;
                word_count_d       = count_next;

                if (sink_endofpacket || (count_next == DEPTH_W)) begin
                    // Either a clean end of packet or a full buffer; the address never wraps.
                    state_d     = DONE;
                    loaded_d    = 1'b1;
                    overflow_d  = !sink_endofpacket;
                    start_req_d = (AUTO_START != 0);
                end else begin
                    state_d = LOAD;
                end
            end
        end
    end

    // Single register bank for the FSM state and every registered output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= IDLE;
            word_count_q       <= '0;
            buffer_write_q     <= 1'b0;
            buffer_address_q   <= '0;
            buffer_writedata_q <= '0;
            loaded_q           <= 1'b0;
            overflow_q         <= 1'b0;
            pkt_error_q        <= 1'b0;
            start_req_q        <= 1'b0;
        end else begin
            state_q            <= state_d;
            word_count_q       <= word_count_d;
            buffer_write_q     <= buffer_write_d;
            buffer_address_q   <= buffer_address_d;
            buffer_writedata_q <= buffer_writedata_d;
            loaded_q           <= loaded_d;
            overflow_q         <= overflow_d;
            pkt_error_q        <= pkt_error_d;
            start_req_q        <= start_req_d;
        end
    end

    assign buffer_write     = buffer_write_q;
    assign buffer_address   = buffer_address_q;
    assign buffer_writedata = buffer_writedata_q;
    assign loaded           = loaded_q;
    assign overflow         = overflow_q;
    assign pkt_error        = pkt_error_q;
    assign word_count       = word_count_q;
    assign start_req        = start_req_q;

endmodule

// File: tb/tb_stream_loader.sv
// tb/tb_stream_loader.sv - scoreboard bench for stream_loader with a packet-level reference model
module tb_stream_loader;

    localparam int TB_BITS = 3;
    localparam int AW      = TB_BITS;
    localparam int DEPTH   = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          sink_valid = 1'b0;
    logic          sink_sop = 1'b0;
    logic          sink_eop = 1'b0;
    logic [31:0]   sink_data = '0;
    logic          sink_ready;
    logic          buffer_write;
    logic [AW-1:0] buffer_address;
    logic [31:0]   buffer_writedata;
    logic          loaded;
    logic          overflow;
    logic          pkt_error;
    logic [AW:0]   word_count;
    logic          start_req;

    stream_loader #(
        .timeBits    (TB_BITS),
        .words_log_2 (0),
        .AUTO_START  (1)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .arm                (arm),
        .abort              (abort),
        .sink_valid         (sink_valid),
        .sink_ready         (sink_ready),
        .sink_data          (sink_data),
        .sink_startofpacket (sink_sop),
        .sink_endofpacket   (sink_eop),
        .buffer_write       (buffer_write),
        .buffer_address     (buffer_address),
        .buffer_writedata   (buffer_writedata),
        .loaded             (loaded),
        .overflow           (overflow),
        .pkt_error          (pkt_error),
        .word_count         (word_count),
        .start_req          (start_req)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_start = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the packet being loaded is a queue of words.
    typedef struct packed {
        bit [31:0] a;
        bit [31:0] d;
    } wr_t;

    wr_t       sbq[$];
    bit [31:0] pkt[$];
    bit        m_acc, m_inpkt, m_loaded, m_ovf, m_perr, m_start;
    bit [31:0] m_last_addr, m_last_data;

    function automatic void model_reset();
        m_acc = 0; m_inpkt = 0; m_loaded = 0; m_ovf = 0; m_perr = 0; m_start = 0;
        m_last_addr = 0; m_last_data = 0;
        pkt.delete();
        sbq.delete();
    endfunction

    function automatic void model_step();
        wr_t w;
        m_start = 0;
        if (abort) begin
            m_acc = 0;
        end else if (arm) begin
            m_acc = 1; m_inpkt = 0; m_loaded = 0; m_ovf = 0; m_perr = 0;
            pkt.delete();
        end else if (sink_valid && m_acc) begin
            if (sink_sop) begin
                if (m_inpkt) m_perr = 1;
                pkt.delete();
                m_inpkt = 1;
            end
            if (m_inpkt) begin
                w.a = 32'(pkt.size());
                w.d = sink_data;
                sbq.push_back(w);
                m_last_addr = w.a;
                m_last_data = w.d;
                pkt.push_back(sink_data);
                if (sink_eop || pkt.size() == DEPTH) begin
                    if (!sink_eop) m_ovf = 1;
                    m_acc = 0; m_inpkt = 0; m_loaded = 1; m_start = 1;
                end
            end
        end
    endfunction

    // Drive one cycle of inputs, let the edge happen, advance the model.
    task automatic cyc(input bit ab, input bit ar, input bit v, input bit s, input bit e, input logic [31:0] d);
        abort = ab; arm = ar; sink_valid = v; sink_sop = s; sink_eop = e; sink_data = d;
        @(posedge clk);
        if (reset_n) model_step();
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, sink_ready, 0);
        chk({tag, "_write"}, buffer_write, 0);
        chk({tag, "_addr"}, buffer_address, 0);
        chk({tag, "_data"}, buffer_writedata, 0);
        chk({tag, "_loaded"}, loaded, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_pkt_error"}, pkt_error, 0);
        chk({tag, "_word_count"}, word_count, 0);
        chk({tag, "_start_req"}, start_req, 0);
    endtask

    // Monitor: compare every cycle's outputs against the model, pop the write scoreboard.
    always @(negedge clk) begin : mon
        wr_t w;
        chk("sink_ready", sink_ready, m_acc);
        chk("loaded", loaded, m_loaded);
        chk("overflow", overflow, m_ovf);
        chk("pkt_error", pkt_error, m_perr);
        chk("word_count", word_count, 32'(pkt.size()));
        chk("start_req", start_req, m_start);
        chk("buffer_write", buffer_write, sbq.size() != 0);
        if (sbq.size() != 0) begin
            w = sbq.pop_front();
            if (buffer_write) begin
                chk("wr_addr", buffer_address, w.a);
                chk("wr_data", buffer_writedata, w.d);
            end
        end else if (!buffer_write) begin
            chk("addr_hold", buffer_address, m_last_addr);
            chk("data_hold", buffer_writedata, m_last_data);
        end
        if (start_req) n_start++;
    end

    initial begin
        int s0;
        int r;
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle();

        // T1: 4-beat packet
        s0 = n_start;
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, i == 0, i == 3, 32'hA0 + 32'(i));
        idle();
        idle();
        chk("t1_word_count", word_count, 4);
        chk("t1_loaded", loaded, 1);
        chk("t1_start_pulses", n_start - s0, 1);

        // T2: overflow at DEPTH with no EOP
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, i == 0, 0, $urandom);
        idle();
        chk("t2_overflow", overflow, 1);
        chk("t2_word_count", word_count, DEPTH);
        chk("t2_ready", sink_ready, 0);

        // T3: leading non-SOP beats discarded (one carries EOP)
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 32'h11);
        cyc(0, 0, 1, 0, 1, 32'h22);
        cyc(0, 0, 1, 1, 1, 32'h55);
        idle();
        chk("t3_word_count", word_count, 1);
        chk("t3_data", buffer_writedata, 32'h55);

        // T4: SOP mid-packet restarts the load
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, i == 0, 0, 32'hB0 + 32'(i));
        cyc(0, 0, 1, 1, 0, 32'hC0);
        cyc(0, 0, 1, 0, 1, 32'hC1);
        idle();
        chk("t4_pkt_error", pkt_error, 1);
        chk("t4_word_count", word_count, 2);
        chk("t4_addr", buffer_address, 1);

        // T5: asynchronous reset mid-load
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, i == 0, 0, 32'hD0 + 32'(i));
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk_all_zero("t5");
        idle();
        idle();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, i == 2, 32'hE0);
        idle();
        chk("t5_word_count", word_count, 0);

        // T6: arm and abort together with a SOP beat while waiting
        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 0, 32'hF0);
        idle();
        chk("t6_ready", sink_ready, 0);
        chk("t6_word_count", word_count, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            cyc(r < 2, (r >= 2) && (r < 7), $urandom_range(0, 3) != 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0, $urandom);
        end
        idle();
        idle();
        chk("scoreboard_empty", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
